// File: rtl/muldiv_pkg.sv
// Shared opcodes, op/state enums for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MULT  = OP_MULT,
    MULTU = OP_MULTU,
    DIV   = OP_DIV,
    DIVU  = OP_DIVU
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the 2N+1-bit accumulator: shift-add for multiply,
// restoring trial-subtract for divide.
module muldiv_step #(
  parameter int unsigned N = 32
) (
  input  logic           div,
  input  logic [2*N:0]   acc,
  input  logic [N-1:0]   opnd,
  output logic [2*N:0]   acc_nxt
);

  logic [N:0]   sum;
  logic [2*N:0] sh;
  logic [N+1:0] diff;

  always_comb begin
    sum     = acc[2*N:N] + {1'b0, opnd};
    sh      = {acc[2*N-1:0], 1'b0};
    diff    = {1'b0, sh[2*N:N]} - {2'b00, opnd};
    acc_nxt = sh;
    if (!div) begin
      // multiplier sits in the low half and is consumed LSB first
      if (acc[0]) acc_nxt = {1'b0, sum, acc[N-1:1]};
      else        acc_nxt = {1'b0, acc[2*N:1]};
    end else if (!diff[N+1]) begin
      acc_nxt = {diff[N:0], sh[N-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers and a
// start/busy/done handshake.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         dz
);

  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned AW = 2 * N + 1;

  muldiv_state_t state, state_n;
  logic [CW-1:0] count;
  muldiv_op_t    op_q;
  logic [N-1:0]  opnd;
  logic [AW-1:0] acc, acc_nxt;
  logic          sign_q, sign_r;

  logic          accept, div_zero, last, in_signed, is_signed, is_div;
  logic [N-1:0]  a_mag, b_mag, quo, rem;
  logic [2*N-1:0] prod;

  muldiv_step #(.N(N)) u_step (
    .div     (is_div),
    .acc     (acc),
    .opnd    (opnd),
    .acc_nxt (acc_nxt)
  );

  // operand conditioning and final sign fix-up
  always_comb begin
    accept    = start && ((state == IDLE) || (state == DONE));
    div_zero  = op[1] && (b == '0);
    in_signed = ~op[0];
    a_mag     = (in_signed && a[N-1]) ? N'(-a) : a;
    b_mag     = (in_signed && b[N-1]) ? N'(-b) : b;
    last      = (state == RUN) && (count == CW'(N - 1));
    is_div    = (op_q == DIV) || (op_q == DIVU);
    is_signed = (op_q == MULT) || (op_q == DIV);
    prod      = acc_nxt[2*N-1:0];
    quo       = acc_nxt[N-1:0];
    rem       = acc_nxt[2*N-1:N];
    if (is_signed && sign_q) begin
      prod = (2*N)'(-acc_nxt[2*N-1:0]);
      quo  = N'(-acc_nxt[N-1:0]);
    end
    if (is_signed && sign_r) rem = N'(-acc_nxt[2*N-1:N]);
  end

  // next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = div_zero ? DONE : RUN;
      RUN:     if (last) state_n = DONE;
      DONE:    if (start) state_n = div_zero ? DONE : RUN;
               else       state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      count  <= '0;
      op_q   <= MULT;
      opnd   <= '0;
      acc    <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      dz     <= 1'b0;
    end else begin
      busy <= (state_n == RUN);
      done <= (state_n == DONE);
      if (accept) begin
        op_q   <= muldiv_op_t'(op);
        sign_q <= a[N-1] ^ b[N-1];
        sign_r <= a[N-1];
        count  <= '0;
        dz     <= 1'b0;
        opnd   <= op[1] ? b_mag : a_mag;
        acc    <= {(N+1)'(0), (op[1] ? a_mag : b_mag)};
        // divide by zero completes on the accept edge
        if (div_zero) begin
          hi <= a;
          lo <= '1;
          dz <= 1'b1;
        end
      end else if (state == RUN) begin
        acc   <= acc_nxt;
        count <= count + CW'(1);
        if (last) begin
          if (is_div) begin
            hi <= rem;
            lo <= quo;
          end else begin
            hi <= prod[2*N-1:N];
            lo <= prod[N-1:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed table-driven bench for muldiv_unit plus handshake corner sequences.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.N(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start an op; returns edges from the accept edge to the first done sample
  // and the number of busy samples seen on the way.
  task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int lat, output int bcnt);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 1; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, dcnt;
    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33};
    vecs[1]  = '{2'b01, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0, 33};
    vecs[2]  = '{2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0, 33};
    vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vecs[4]  = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0, 33};
    vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
    vecs[6]  = '{2'b11, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1, 1};
    vecs[7]  = '{2'b10, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 1'b1, 1};
    vecs[8]  = '{2'b00, 32'hFFFFFFFD, 32'hFFFFFFFB, 32'h00000000, 32'h0000000F, 1'b0, 33};
    vecs[9]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 33};
    vecs[10] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33};
    vecs[11] = '{2'b11, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 33};
    vecs[12] = '{2'b10, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002, 1'b0, 33};

    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    chk("reset_dz", 32'(dz), 32'd0);

    for (int i = 0; i < 13; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'(vecs[i].lat - 1));
      chk($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      chk($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      chk($sformatf("v%0d_dz", i), 32'(dz), 32'(vecs[i].dz));
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), 32'(done), 32'd0);
    end

    // start pulsed during RUN is ignored
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      if (lat == 10) begin
        start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk("ignore_latency", 32'(lat), 32'd33);
    chk("ignore_hi", hi, 32'd0);
    chk("ignore_lo", lo, 32'd12);
    @(negedge clk);

    // back-to-back: start in the DONE cycle
    do_op(2'b01, 32'd6, 32'd7, lat, bcnt);
    chk("b2b_first_lo", lo, 32'd42);
    start = 1'b1; op = 2'b11; a = 32'd100; b = 32'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done_fall", 32'(done), 32'd0);
    chk("b2b_busy_rise", 32'(busy), 32'd1);
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("b2b_latency", 32'(lat), 32'd33);
    chk("b2b_hi", hi, 32'd2);
    chk("b2b_lo", lo, 32'd14);
    @(negedge clk);

    // reset at cycle 10 of a DIVU
    start = 1'b1; op = 2'b11; a = 32'd1000; b = 32'd3;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    dcnt = 0;
    repeat (40) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);
    do_op(2'b11, 32'd7, 32'd2, lat, bcnt);
    chk("after_abort_latency", 32'(lat), 32'd33);
    chk("after_abort_hi", hi, 32'd1);
    chk("after_abort_lo", lo, 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
